// File: rtl/hp_bcd_packer_pkg.sv
// hp_pkg: shared FSM state type and sizing constants for the hit-point BCD packer
package hp_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, GAP} hp_state_t;
    localparam int NUM_HP        = 4;
    localparam int DIGITS_PER_HP = 2;
    localparam int BCD_W         = 8;
endpackage

// File: rtl/hp_bcd_packer_if.sv
// hp_bcd_packer_if: hit-point input bus and packed BCD display output bundle
interface hp_bcd_packer_if
    import hp_pkg::*;
#(
    parameter int HP_WIDTH = 8
);
    logic [NUM_HP*HP_WIDTH-1:0] hp_in;
    logic [NUM_HP*BCD_W-1:0]    val_out;
    logic                       valid_out;
    logic                       busy_out;
    modport master (output hp_in, input val_out, valid_out, busy_out);
    modport slave  (input hp_in, output val_out, valid_out, busy_out);
endinterface

// File: rtl/hp_bcd_packer_bcd_dd_step.sv
// bcd_dd_step: one double-dabble iteration (add-3 correction then shift left) on {bcd, bin}
module bcd_dd_step
    import hp_pkg::*;
#(
    parameter int HP_WIDTH = 8
) (
    input  logic [BCD_W-1:0]    bcd_i,
    input  logic [HP_WIDTH-1:0] bin_i,
    output logic [BCD_W-1:0]    bcd_o,
    output logic [HP_WIDTH-1:0] bin_o
);
    logic [3:0] hi, lo;
    assign hi = (bcd_i[7:4] >= 4'd5) ? bcd_i[7:4] + 4'd3 : bcd_i[7:4];
    assign lo = (bcd_i[3:0] >= 4'd5) ? bcd_i[3:0] + 4'd3 : bcd_i[3:0];
    // The hundreds carry out of hi[3] is dropped; saturation keeps it zero.
    assign {bcd_o, bin_o} = {hi[2:0], lo, bin_i, 1'b0};
endmodule

// File: rtl/hp_bcd_packer.sv
// hp_bcd_packer: saturate four hit-point values, convert each to two BCD digits with one
// shared sequential double-dabble, and publish the packed word once per sweep.
// Optional HP_STABLE_EN: LOAD waits for two consecutive matching samples of the slot.
module hp_bcd_packer
    import hp_pkg::*;
#(
    parameter int HP_WIDTH  = 8,
    parameter int MAX_SHOWN = 99,
    parameter int SWEEP_GAP = 0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    hp_bcd_packer_if.slave  bus
);
    localparam int IW = $clog2(HP_WIDTH);
    localparam int SW = $clog2(NUM_HP);

    hp_state_t                 state_q;
    logic [SW-1:0]             slot_q;
    logic [IW-1:0]             iter_q;
    logic [15:0]               gap_q;
    logic [BCD_W-1:0]          bcd_q;
    logic [HP_WIDTH-1:0]       bin_q;
    logic [NUM_HP*BCD_W-1:0]   shadow_q;
    logic [NUM_HP*BCD_W-1:0]   val_q;
    logic                      valid_q;
    logic                      busy_q;
`ifdef HP_STABLE_EN
    logic [HP_WIDTH-1:0]       samp_q;
    logic                      seen_q;
`endif

    logic [HP_WIDTH-1:0] slice, sat;
    logic [BCD_W-1:0]    bcd_step;
    logic [HP_WIDTH-1:0] bin_step;

    assign slice = bus.hp_in[HP_WIDTH*(NUM_HP-1-int'(slot_q)) +: HP_WIDTH];
    assign sat   = (slice > HP_WIDTH'(MAX_SHOWN)) ? HP_WIDTH'(MAX_SHOWN) : slice;

    bcd_dd_step #(.HP_WIDTH(HP_WIDTH)) u_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (bcd_step),
        .bin_o (bin_step)
    );

    assign bus.val_out   = val_q;
    assign bus.valid_out = valid_q;
    assign bus.busy_out  = busy_q;

    // Sweep sequencer: load/convert/store each slot in turn, publish the whole word on slot 3.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            iter_q   <= '0;
            gap_q    <= '0;
            bcd_q    <= '0;
            bin_q    <= '0;
            shadow_q <= '0;
            val_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef HP_STABLE_EN
            samp_q   <= '0;
            seen_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    slot_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= LOAD;
                end
                LOAD: begin
`ifdef HP_STABLE_EN
                    samp_q <= slice;
                    seen_q <= 1'b1;
                    if (seen_q && slice == samp_q) begin
                        bin_q   <= sat;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        seen_q  <= 1'b0;
                        state_q <= SHIFT;
                    end
`else
                    bin_q   <= sat;
                    bcd_q   <= '0;
                    iter_q  <= '0;
                    state_q <= SHIFT;
`endif
                end
                SHIFT: begin
                    bcd_q  <= bcd_step;
                    bin_q  <= bin_step;
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == IW'(HP_WIDTH-1))
                        state_q <= STORE;
                end
                STORE: begin
                    shadow_q[BCD_W*(NUM_HP-1-int'(slot_q)) +: BCD_W] <= bcd_q;
                    if (slot_q == SW'(NUM_HP-1)) begin
                        val_q   <= {shadow_q[NUM_HP*BCD_W-1:BCD_W], bcd_q};
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        slot_q  <= slot_q + 1'b1;
                        state_q <= LOAD;
                    end
                end
                GAP: begin
                    if (gap_q == 16'(SWEEP_GAP)) begin
                        slot_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/hp_bcd_packer.md
Name: hp_bcd_packer

Overview:
- Converts the four 8-bit tower hit-point values from singleprocessor (hp00, hp01, hp10, hp11) into two-digit decimal and packs them into the 32-bit val_in word consumed by seven_segment_controller.
- Sits between singleprocessor and seven_segment_controller on the buf_clk domain.
- Uses a sequential double-dabble converter shared round-robin across the four values.
- The display word updates atomically once per full sweep.

Parameters:
- HP_WIDTH, 8, width of each hit-point value.
- MAX_SHOWN, 99, saturation ceiling. Must be ≤ 99 so two BCD digits suffice.
- SWEEP_GAP, 0, idle cycles inserted after each completed sweep before the next one starts (0 to 65535).

Ports:
- clk_in  input  1  system clock (buf_clk).
- rst_in  input  1  asynchronous, active-low reset.
- hp_in  input  4*HP_WIDTH  packed {hp00, hp01, hp10, hp11}; hp00 in the MSBs (slot 0).
- val_out  output  32  packed BCD. Slot k occupies bits [31-8k -: 8], tens digit in the upper nibble.
- valid_out  output  1  one-cycle pulse when val_out has just been updated.
- busy_out  output  1  high while a sweep is in progress.

Interface: one clock; reset is asynchronous and active-low. Ports are clk_in and rst_in.

Behaviour:
- Reset (rst_in low, asynchronous): val_out=32'h0, valid_out=0, busy_out=0, state=IDLE, slot index=0, gap counter=0, shadow register=0.
- FSM states: IDLE, LOAD, SHIFT, STORE, GAP.
- IDLE: on the first clock after reset release, go to LOAD with slot=0, busy_out=1.
- LOAD (1 cycle):
  - Capture hp_in slice for the current slot.
  - If value > MAX_SHOWN, substitute MAX_SHOWN.
  - Clear the 8-bit BCD accumulator; iteration counter=0.
- SHIFT (HP_WIDTH cycles), each cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {bcd, bin} left by one bit.
  - After the HP_WIDTH-th shift, go to STORE.
  - The hundreds overflow bit is discarded; it is guaranteed zero by saturation.
- STORE (1 cycle):
  - Write the BCD byte into the shadow register slot.
  - If slot==3, copy the full shadow (including this byte) to val_out, pulse valid_out, go to GAP.
  - Otherwise increment slot and go to LOAD.
- GAP:
  - busy_out=0.
  - Count SWEEP_GAP cycles, then slot=0, busy_out=1, go to LOAD.
  - With SWEEP_GAP=0, GAP lasts exactly 1 cycle.
- Latency:
  - Per slot: HP_WIDTH+2 cycles (10 at default).
  - Full sweep: 40 cycles at default.
  - valid_out is asserted in the cycle after the slot-3 STORE edge, i.e. together with the new val_out.
- Sampling: each slot is sampled only in its LOAD cycle. Input changes mid-sweep affect only slots not yet loaded; no tearing within a slot.
- val_out never shows a partial sweep; it only changes on the valid_out cycle.
- Reset mid-sweep: all state aborts immediately and val_out returns to 0. The next valid_out comes 40+1 cycles after release (default params).
- hp value 0 displays 8'h00; no blanking.

Optional Feature:
- Macro: HP_STABLE_EN.
- Defined:
  - LOAD becomes two cycles. The slice is sampled in both cycles.
  - If the samples differ, stay in LOAD (re-sample each cycle) until two consecutive samples match, then proceed.
  - Filters transient values from the processor's hp update path.
  - Per-slot latency grows to HP_WIDTH+3 minimum.
- Undefined: single-cycle LOAD as above.

Decomposition:
- Package hp_pkg holds:
  - state enum hp_state_t {IDLE, LOAD, SHIFT, STORE, GAP};
  - localparams NUM_HP=4, DIGITS_PER_HP=2, BCD_W=8.
- One sub-module, bcd_dd_step: combinational single double-dabble iteration (add-3 correction plus shift) on {bcd[7:0], bin[HP_WIDTH-1:0]}. Instantiated once in the SHIFT datapath.

Test Plan:
- Reset with hp_in=32'h0A_14_1E_28 (10,20,30,40), release → valid_out pulses 41 cycles later (default params); val_out=32'h10203040.
- hp_in={8'd255, 8'd100, 8'd99, 8'd0} → val_out=32'h99999900 (saturation of 255 and 100; 99 exact; zero shown as 00).
- Steady inputs with SWEEP_GAP=0 → valid_out period is exactly 41 cycles. busy_out low only in the GAP cycle.
- Change hp11 from 5 to 7 while slot 1 is in SHIFT → current sweep shows 07 in slot 3. Change hp00 at the same point → new value appears only in the following sweep.
- Assert rst_in low for 1 cycle mid-SHIFT of slot 2 → val_out=0 and busy_out=0 asynchronously; first valid_out 41 cycles after release.
- HP_STABLE_EN defined: toggle slot 0 input every cycle for 20 cycles, then hold 42 → no valid_out until stable; val_out[31:24]=8'h42.
